// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator (640x480@60 by default).
// Divides the system clock down to the pixel rate, runs the x/y raster
// counters and produces registered hsync/vsync/video_on/frame_start.
// Optional build macro VGA_SYNC_FRAME_CNT_EN adds an 8-bit frame counter
// output (frame_cnt) that steps on every frame_start.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_VISIBLE + V_FP + V_SYNC;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    // Low for the first cycle after reset so pixel_tick reads 0 at reset even when CLK_DIV=1.
    logic             run;
    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             line_end;
    logic             frame_wrap;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             video_on_nxt;

    // Pixel strobe: last divider phase, only once the generator is running.
    assign pixel_tick = run && (div == DIV_W'(CLK_DIV - 1));

    // Next-state divider/counters and sync decode of the next raster position.
    always_comb begin
        div_nxt    = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
        x_nxt      = pixel_x;
        y_nxt      = pixel_y;
        line_end   = (pixel_x == CNT_W'(H_TOTAL - 1));
        frame_wrap = pixel_tick && line_end && (pixel_y == CNT_W'(V_TOTAL - 1));
        if (pixel_tick) begin
            if (line_end) begin
                x_nxt = '0;
                y_nxt = (pixel_y == CNT_W'(V_TOTAL - 1)) ? '0 : pixel_y + CNT_W'(1);
            end else begin
                x_nxt = pixel_x + CNT_W'(1);
            end
        end
        hsync_nxt    = !((x_nxt >= CNT_W'(H_SYNC_START)) && (x_nxt < CNT_W'(H_SYNC_END)));
        vsync_nxt    = !((y_nxt >= CNT_W'(V_SYNC_START)) && (y_nxt < CNT_W'(V_SYNC_END)));
        video_on_nxt = (x_nxt < CNT_W'(H_VISIBLE)) && (y_nxt < CNT_W'(V_VISIBLE));
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run         <= 1'b0;
            div         <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            div         <= div_nxt;
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            video_on    <= video_on_nxt;
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Frame counter steps on the same edge that raises frame_start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'(1);
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: default horizontal timing, CLK_DIV=4,
// vertical timing shrunk to 12 lines (6 visible, vsync on lines 8..9) so a
// whole frame fits in 38,400 clks. Expected raster states are keyed by the
// number of clock edges since reset release.
module tb_vga_sync_gen;

    typedef struct {
        int          phase;
        int          n;
        string       name;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        tk;
        logic        fs;
        logic [7:0]  fc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pixel_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    vec_t exp_q[$];
    int   n = 0;
    int   phase = 0;
    bit   was_running = 1'b0;
    bit   done = 1'b0;
    int   applied = 0;
    int   errors = 0;
    int   fs_pulses = 0;

    vga_sync_gen #(
        .CLK_DIV  (4),
        .V_VISIBLE(6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_tick (pixel_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_start(frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Edge counter since release; phase advances on each new reset assertion.
    always @(posedge clk) begin
        if (!rst_n) begin
            n <= 0;
            if (was_running) phase <= phase + 1;
            was_running <= 1'b0;
        end else begin
            n <= n + 1;
            was_running <= 1'b1;
        end
    end

    task automatic add(input int ph, input int nn, input string nm,
                       input int x, input int y, input int hs, input int vs,
                       input int vo, input int tk, input int fs, input int fc);
        vec_t v;
        v.phase = ph; v.n = nn; v.name = nm;
        v.x = 10'(x); v.y = 10'(y);
        v.hs = 1'(hs); v.vs = 1'(vs); v.vo = 1'(vo);
        v.tk = 1'(tk); v.fs = 1'(fs); v.fc = 8'(fc);
        exp_q.push_back(v);
    endtask

    // Monitor: pops expected states when the edge count reaches them.
    initial begin
        vec_t v;
        bit   bad;
        forever begin
            @(negedge clk);
            if (frame_start) fs_pulses++;
            while (exp_q.size() > 0 &&
                   (exp_q[0].phase < phase || (exp_q[0].phase == phase && exp_q[0].n < n))) begin
                v = exp_q.pop_front();
                applied++;
                errors++;
                $display("FAIL %s: edge %0d of phase %0d never observed (now phase %0d edge %0d)",
                         v.name, v.n, v.phase, phase, n);
            end
            if (exp_q.size() > 0 && exp_q[0].phase == phase && exp_q[0].n == n) begin
                v = exp_q.pop_front();
                applied++;
                bad = (pixel_x !== v.x) || (pixel_y !== v.y) || (hsync !== v.hs) ||
                      (vsync !== v.vs) || (video_on !== v.vo) || (pixel_tick !== v.tk) ||
                      (frame_start !== v.fs);
`ifdef VGA_SYNC_FRAME_CNT_EN
                bad = bad || (frame_cnt !== v.fc);
`endif
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b vo=%b tk=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b vo=%b tk=%b fs=%b",
                             v.name, pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start,
                             v.x, v.y, v.hs, v.vs, v.vo, v.tk, v.fs);
`ifdef VGA_SYNC_FRAME_CNT_EN
                    $display("  %s frame_cnt got %0d want %0d", v.name, frame_cnt, v.fc);
`endif
                end
            end
            if (done) begin
                while (exp_q.size() > 0) begin
                    v = exp_q.pop_front();
                    applied++;
                    errors++;
                    $display("FAIL %s: not reached before end of run", v.name);
                end
                applied++;
                if (fs_pulses != 1) begin
                    errors++;
                    $display("FAIL frame_start_count: got %0d pulses, want 1", fs_pulses);
                end
                $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
                $finish;
            end
        end
    end

    // Driver: reset, long run with mid-frame reset, short run after re-release.
    initial begin
        int guard;
        //   ph  edge   name              x    y  hs vs vo tk fs fc
        add(0,     0, "reset_state",       0,   0, 1, 1, 0, 0, 0, 0);
        add(0,     1, "first_edge",        0,   0, 1, 1, 1, 0, 0, 0);
        add(0,     3, "first_tick",        0,   0, 1, 1, 1, 1, 0, 0);
        add(0,     4, "x_to_1",            1,   0, 1, 1, 1, 0, 0, 0);
        add(0,     7, "second_tick",       1,   0, 1, 1, 1, 1, 0, 0);
        add(0,  2559, "last_visible_x",  639,   0, 1, 1, 1, 1, 0, 0);
        add(0,  2560, "video_off_640",   640,   0, 1, 1, 0, 0, 0, 0);
        add(0,  2623, "before_hsync",    655,   0, 1, 1, 0, 1, 0, 0);
        add(0,  2624, "hsync_fall_656",  656,   0, 0, 1, 0, 0, 0, 0);
        add(0,  3007, "hsync_last_751",  751,   0, 0, 1, 0, 1, 0, 0);
        add(0,  3008, "hsync_rise_752",  752,   0, 1, 1, 0, 0, 0, 0);
        add(0,  3199, "line_end_799",    799,   0, 1, 1, 0, 1, 0, 0);
        add(0,  3200, "line_wrap",         0,   1, 1, 1, 1, 0, 0, 0);
        add(0, 25599, "before_vsync",    799,   7, 1, 1, 0, 1, 0, 0);
        add(0, 25600, "vsync_fall_y8",     0,   8, 1, 0, 0, 0, 0, 0);
        add(0, 31999, "vsync_last_y9",   799,   9, 1, 0, 0, 1, 0, 0);
        add(0, 32000, "vsync_rise_y10",    0,  10, 1, 1, 0, 0, 0, 0);
        add(0, 38399, "frame_end",       799,  11, 1, 1, 0, 1, 0, 0);
        add(0, 38400, "frame_start_hi",    0,   0, 1, 1, 1, 0, 1, 1);
        add(0, 38401, "frame_start_lo",    0,   0, 1, 1, 1, 0, 0, 1);
        add(0, 70000, "pre_reset_700_9", 700,   9, 0, 0, 0, 0, 0, 1);
        add(1,     0, "mid_reset_state",   0,   0, 1, 1, 0, 0, 0, 0);
        add(1,     1, "restart_edge",      0,   0, 1, 1, 1, 0, 0, 0);
        add(1,     4, "restart_x_1",       1,   0, 1, 1, 1, 0, 0, 0);
        add(1,  3200, "restart_line",      0,   1, 1, 1, 1, 0, 0, 0);
        add(1,  3999, "restart_x199",    199,   1, 1, 1, 1, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        guard = 0;
        while (!(phase == 0 && n == 70000) && guard < 80000) begin
            @(negedge clk);
            guard++;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        guard = 0;
        while (!(phase == 1 && n >= 4000) && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        done = 1'b1;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 raster timing: pixel_x, pixel_y and video_on for the pixel renderer, plus hsync and vsync for the connector.
- Sits between the system clock and the combinational RGB renderer; the renderer's colour outputs go straight to the VGA pins.
- Derives the pixel rate from the system clock with an internal divider and emits pixel_tick and frame_start strobes for game-logic timing (cursor blink, input sampling).

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pixel_tick  out  1  one-clk pulse; counters advance on the next edge
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  vertical count, 0..V_TOTAL-1
- video_on  out  1  high when pixel_x<H_VISIBLE and pixel_y<V_VISIBLE
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). All counts are unsigned 10-bit.
- Reset values (rst_n low at a clk edge; takes effect that edge):
  - div counter=0, pixel_x=0, pixel_y=0.
  - hsync=1, vsync=1, video_on=0, pixel_tick=0, frame_start=0.
  - A reset mid-line or mid-frame behaves identically; there is no partial-state retention.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is combinational: high when div==CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is constant 1 out of reset, so the counters advance every clk.
- Counters advance only on an edge where pixel_tick=1:
  - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps from V_TOTAL-1 to 0 on the same edge that pixel_x wraps.
  - No other transitions exist.
- hsync, vsync and video_on are registered and decoded from next-state counter values, so they change on the same edge as pixel_x/pixel_y (zero skew to the counters):
  - hsync=0 iff H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vsync=0 iff V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC (490..491).
  - video_on=1 on the first edge after reset release, because (0,0) is visible.
- frame_start is registered:
  - High for exactly one clk, coincident with the first cycle in which (pixel_x,pixel_y)=(0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - It is not asserted on reset exit.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000 at defaults).
- Reset has priority over every other event.

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt, out, 8 bits, reset 0.
  - Increments modulo 256 on the same edge frame_start is set; 255 wraps to 0.
  - Used for cursor blink (bit 4 toggles roughly every 0.27 s).
- Undefined: the port and its register are absent; all other behaviour is unchanged.

Test Plan:
- Reset then release, CLK_DIV=4:
  - pixel_tick is high every 4th clk starting at the 4th clk.
  - pixel_x reaches 1 on the 4th edge.
  - hsync=vsync=1 and video_on=1 after the first edge.
- Line timing:
  - Full line spans 3200 clks.
  - hsync falls when pixel_x becomes 656 (clk 2624 of line) and stays low for 384 clks.
  - video_on falls when pixel_x becomes 640.
- Frame timing:
  - vsync is low exactly while pixel_y is 490..491 (2 lines = 6400 clks).
  - pixel_y wraps 524->0.
  - frame_start pulses once per 1,680,000 clks and is 1 clk wide.
- Reset mid-operation:
  - Assert rst_n=0 at pixel (700,491) while hsync=0 and vsync=0.
  - Next edge: all outputs at reset values.
  - Release: the count restarts from (0,0) with no frame_start.
- CLK_DIV=1: counters advance every clk; the line is 800 clks and the frame is 420,000 clks.
- VGA_SYNC_FRAME_CNT_EN defined: after 257 frame_start pulses, frame_cnt=1; it increments on the same edge as each frame_start.
